// File: rtl/free_list_ctrl_if.sv
// Shared physical-register type and the rename-side alloc/free bundle
// used between rename/retire and the free list.
package Types;
  localparam int P_W = 7;
  typedef logic [P_W-1:0] p_reg;
endpackage

interface free_list_if;
  import Types::*;
  logic i_alloc_req  [0:1];
  p_reg o_alloc_preg [0:1];
  logic o_alloc_ready;
  p_reg i_free_PRegs [0:1];

  modport master (
    output i_alloc_req, i_free_PRegs,
    input  o_alloc_preg, o_alloc_ready
  );
  modport slave (
    input  i_alloc_req, i_free_PRegs,
    output o_alloc_preg, o_alloc_ready
  );
endinterface

// File: rtl/free_list_ctrl.sv
// Physical register free list: circular FIFO, 2-wide alloc and free.
// FREE_LIST_CHECK_EN adds an in-list bitmap that drops and flags bad frees.
module free_list_ctrl
  import Types::*;
#(
  parameter  int NUM_PREGS = 128,
  parameter  int NUM_AREGS = 32,
  localparam int CAP       = NUM_PREGS - NUM_AREGS,
  localparam int CW        = $clog2(CAP + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  free_list_if.slave    fl,
  output logic [CW-1:0] o_free_count,
  output logic          o_init_done,
  output logic          o_err
);
  localparam int IW = $clog2(CAP);
  localparam int KW = $clog2(CAP / 2);
  localparam logic [KW-1:0] K_LAST = KW'(CAP / 2 - 1);
  localparam logic [IW:0]   CAP_W  = (IW + 1)'(CAP);
  localparam logic [CW-1:0] CAP_C  = CW'(CAP);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e        state_q;
  p_reg          fifo_q [CAP];
  logic [IW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic [KW-1:0] k_q;
  logic          done_q;

  logic          run, ready;
  logic [IW-1:0] hp1, tp1, head_d, tail_d;
  logic [1:0]    n_alloc, n_free;
  logic [CW-1:0] cnt_aa, count_d;
  logic          ok0, ok1, f0, f1, err_d;
  p_reg          fr0, fr1;

  function automatic logic [IW-1:0] wrap_add(
    input logic [IW-1:0] a,
    input logic [1:0]    n
  );
    logic [IW:0] s;
    s = {1'b0, a} + {{(IW-1){1'b0}}, n};
    if (s >= CAP_W) s = s - CAP_W;
    return s[IW-1:0];
  endfunction

`ifdef FREE_LIST_CHECK_EN
  logic [NUM_PREGS-1:0] inlist_q;
  logic                 err_q;
  logic                 bad0, bad1;
`endif

  always_comb begin
    run   = (state_q == S_RUN);
    ready = run && (count_q >= CW'(2));
    hp1   = wrap_add(head_q, 2'd1);
    tp1   = wrap_add(tail_q, 2'd1);
    fr0   = fl.i_free_PRegs[0];
    fr1   = fl.i_free_PRegs[1];
    fl.o_alloc_ready   = ready;
    fl.o_alloc_preg[0] = run ? fifo_q[head_q] : '0;
    fl.o_alloc_preg[1] = '0;
    if (run)
      fl.o_alloc_preg[1] = fl.i_alloc_req[0] ?
                           fifo_q[hp1] : fifo_q[head_q];
    n_alloc = 2'd0;
    if (ready)
      n_alloc = {1'b0, fl.i_alloc_req[0]} +
                {1'b0, fl.i_alloc_req[1]};
    cnt_aa = count_q - CW'(n_alloc);
`ifdef FREE_LIST_CHECK_EN
    bad0 = (fr0 != '0) &&
           (!run || int'(fr0) >= NUM_PREGS || inlist_q[fr0]);
    bad1 = (fr1 != '0) &&
           (!run || int'(fr1) >= NUM_PREGS || inlist_q[fr1] ||
            fr1 == fr0);
    ok0   = run && (fr0 != '0) && !bad0;
    ok1   = run && (fr1 != '0) && !bad1;
    err_d = bad0 || bad1;
`else
    ok0   = run && (fr0 != '0);
    ok1   = run && (fr1 != '0);
    err_d = 1'b0;
`endif
    // lane 0 claims space first; anything past CAP is dropped
    f0      = ok0 && (cnt_aa < CAP_C);
    f1      = ok1 && ((cnt_aa + CW'(f0)) < CAP_C);
    n_free  = {1'b0, f0} + {1'b0, f1};
    count_d = cnt_aa + CW'(n_free);
    head_d  = wrap_add(head_q, n_alloc);
    tail_d  = wrap_add(tail_q, n_free);
  end

  always_ff @(posedge i_clk) begin
    if (state_q == S_INIT) begin
      fifo_q[IW'(2 * int'(k_q))]     <= p_reg'(NUM_AREGS + 2 * int'(k_q));
      fifo_q[IW'(2 * int'(k_q) + 1)] <= p_reg'(NUM_AREGS + 2 * int'(k_q) + 1);
    end else begin
      if (f0) fifo_q[tail_q] <= fr0;
      if (f1) fifo_q[f0 ? tp1 : tail_q] <= fr1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_INIT;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          k_q <= k_q + KW'(1);
          if (k_q == K_LAST) begin
            state_q <= S_RUN;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CAP_C;
            done_q  <= 1'b1;
          end
        end
        S_RUN: begin
          head_q  <= head_d;
          tail_q  <= tail_d;
          count_q <= count_d;
        end
      endcase
    end
  end

`ifdef FREE_LIST_CHECK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inlist_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= err_d;
      if (state_q == S_INIT) begin
        inlist_q[NUM_AREGS + 2 * int'(k_q)]     <= 1'b1;
        inlist_q[NUM_AREGS + 2 * int'(k_q) + 1] <= 1'b1;
      end else begin
        if (ready && fl.i_alloc_req[0])
          inlist_q[fl.o_alloc_preg[0]] <= 1'b0;
        if (ready && fl.i_alloc_req[1])
          inlist_q[fl.o_alloc_preg[1]] <= 1'b0;
        if (f0) inlist_q[fr0] <= 1'b1;
        if (f1) inlist_q[fr1] <= 1'b1;
      end
    end
  end
  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  assign o_free_count = count_q;
  assign o_init_done  = done_q;
endmodule

// File: tb/tb_free_list_ctrl.sv
// Directed vector bench for free_list_ctrl: init fill, drain,
// refill from empty, same-cycle alloc/free, lane-1-only, async reset.
module tb_free_list_ctrl;
  import Types::*;

`ifdef FREE_LIST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] free_count;
  logic       init_done, err;

  free_list_if fl();

  free_list_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .fl           (fl),
    .o_free_count (free_count),
    .o_init_done  (init_done),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit r0, r1;
    int f0, f1;
    bit rdy;
    int p0, p1, cnt;
    bit err;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input bit r0, input bit r1,
                       input int f0, input int f1);
    fl.i_alloc_req[0]  = r0;
    fl.i_alloc_req[1]  = r1;
    fl.i_free_PRegs[0] = p_reg'(f0);
    fl.i_free_PRegs[1] = p_reg'(f1);
  endtask

  task automatic wait_init(input string nm);
    int n;
    n = 0;
    while (!init_done && n < 100) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk(nm, n, 48);
  endtask

  function automatic vec_t mk(bit r0, bit r1, int f0, int f1,
                              bit rdy, int p0, int p1, int cnt, bit e);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.f0 = f0; v.f1 = f1;
    v.rdy = rdy; v.p0 = p0; v.p1 = p1; v.cnt = cnt; v.err = e;
    return v;
  endfunction

  initial begin
    tbl.push_back(mk(0, 0, 40, 41, 1, 32, 32, 96, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32, 32, 96, CHK));
    for (int i = 0; i < 48; i++)
      tbl.push_back(mk(1, 1, 0, 0, 1, 32 + 2 * i, 33 + 2 * i,
                       96 - 2 * i, 0));
    tbl.push_back(mk(1, 1, 5, 0, 0, 32, 33, 0, 0));
    tbl.push_back(mk(1, 1, 7, 0, 0, 5, 33, 1, 0));
    tbl.push_back(mk(1, 1, 9, 11, 1, 5, 7, 2, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 9, 11, 2, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 11, 11, 1, 0));
    tbl.push_back(mk(0, 0, 13, 15, 0, 11, 11, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 11, 11, 3, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 13, 15, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 38, 38, 0, 0));

    drive(0, 0, 0, 0);
    #12;
    chk("rst_ready", int'(fl.o_alloc_ready), 0);
    chk("rst_count", int'(free_count), 0);
    chk("rst_done", int'(init_done), 0);
    chk("rst_preg0", int'(fl.o_alloc_preg[0]), 0);
    chk("rst_err", int'(err), 0);

    @(negedge clk);
    rst_n = 1'b1;
    wait_init("init_cycles");

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].r0, tbl[i].r1, tbl[i].f0, tbl[i].f1);
      #1;
      chk($sformatf("v%0d_ready", i), int'(fl.o_alloc_ready), int'(tbl[i].rdy));
      chk($sformatf("v%0d_p0", i), int'(fl.o_alloc_preg[0]), tbl[i].p0);
      chk($sformatf("v%0d_p1", i), int'(fl.o_alloc_preg[1]), tbl[i].p1);
      chk($sformatf("v%0d_count", i), int'(free_count), tbl[i].cnt);
      chk($sformatf("v%0d_err", i), int'(err), int'(tbl[i].err));
    end

    // async reset mid-operation, refill, then lane-1-only grant
    @(negedge clk);
    drive(1, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", int'(free_count), 0);
    chk("mid_rst_ready", int'(fl.o_alloc_ready), 0);
    chk("mid_rst_done", int'(init_done), 0);
    chk("mid_rst_p1", int'(fl.o_alloc_preg[1]), 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("reinit_cycles");

    @(negedge clk);
    drive(0, 1, 0, 0);
    #1;
    chk("l1_ready", int'(fl.o_alloc_ready), 1);
    chk("l1_p1", int'(fl.o_alloc_preg[1]), 32);
    @(negedge clk);
    drive(1, 1, 0, 0);
    #1;
    chk("l1_count", int'(free_count), 95);
    chk("l1_p0", int'(fl.o_alloc_preg[0]), 33);
    chk("l1_p1b", int'(fl.o_alloc_preg[1]), 34);

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst2_count", int'(free_count), 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("reinit2_cycles");
    @(negedge clk);
    drive(1, 1, 0, 0);
    #1;
    chk("refill_p0", int'(fl.o_alloc_preg[0]), 32);
    chk("refill_p1", int'(fl.o_alloc_preg[1]), 33);
    chk("refill_count", int'(free_count), 96);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/free_list_ctrl.md
FREE_LIST_CTRL -- requirements
Module: free_list_ctrl

Interface
REQ-001 SHALL have parameter NUM_PREGS, default 128, total physical registers p0..p(NUM_PREGS-1).
REQ-002 SHALL have parameter NUM_AREGS, default 32, architectural registers; p0..p(NUM_AREGS-1) start mapped, never initially free.
REQ-003 SHALL define CAP = NUM_PREGS-NUM_AREGS (96) as free-list capacity; preg fields use type p_reg from Types.
REQ-004 SHALL have i_clk, input, 1, sole clock, all state on rising edge.
REQ-005 SHALL have i_rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have i_alloc_req [0:1], input, 1 each, per-lane destination allocation request from rename.
REQ-007 SHALL have o_alloc_preg [0:1], output, p_reg each, preg offered to each lane.
REQ-008 SHALL have o_alloc_ready, output, 1, allocation permitted this cycle.
REQ-009 SHALL have i_free_PRegs [0:1], input, p_reg each, retired old destinations; value 0 means no free.
REQ-010 SHALL have o_free_count, output, $clog2(CAP+1), entries currently in list.
REQ-011 SHALL have o_init_done, output, 1, high once initial fill completes.
REQ-012 SHALL have o_err, output, 1, illegal-free pulse (see Configuration).

Function
REQ-013 SHALL hold free pregs in a CAP-entry circular FIFO with head, tail and count registers.
REQ-014 SHALL implement FSM states S_INIT and S_RUN; reset enters S_INIT.
REQ-015 In S_INIT SHALL write two entries per cycle, fifo[2k]=NUM_AREGS+2k, fifo[2k+1]=NUM_AREGS+2k+1, for k=0..CAP/2-1 (48 cycles).
REQ-016 After the last S_INIT write SHALL enter S_RUN with head=0, tail=0, count=CAP, o_init_done=1 from the following cycle onward.
REQ-017 In S_INIT SHALL hold o_alloc_ready=0 and drop all i_free_PRegs.
REQ-018 o_alloc_ready SHALL be combinational: 1 iff state is S_RUN and count>=2 (all-or-nothing, regardless of request mask).
REQ-019 o_alloc_preg[0] SHALL equal fifo[head]; o_alloc_preg[1] SHALL equal fifo[head+1] if i_alloc_req[0] else fifo[head] (combinational, zero latency).
REQ-020 An allocation SHALL occur on a clock edge where o_alloc_ready=1; head advances by popcount(i_alloc_req).
REQ-021 Each nonzero i_free_PRegs entry in S_RUN SHALL be written at tail, lane 0 first, compacted; tail advances by number of nonzero frees.
REQ-022 Head and tail SHALL wrap from CAP-1 to 0 (non-power-of-two modulus, explicit compare).
REQ-023 count_next SHALL equal count - n_alloc + n_free; pregs freed in a cycle SHALL NOT be offered for allocation until the next cycle.
REQ-024 Frees that would push count above CAP SHALL be dropped, count saturating at CAP.
REQ-025 With count<2, o_alloc_ready=0 and requests SHALL be ignored with no state change from them; same-cycle frees still land.

Reset
REQ-026 Assertion of i_rst_n=0 SHALL immediately clear head, tail, count, o_init_done, o_err and force S_INIT, including mid-operation.
REQ-027 During reset o_alloc_ready=0, o_free_count=0, o_alloc_preg[0:1]=0.

Configuration
REQ-028 Macro FREE_LIST_CHECK_EN defined SHALL add a NUM_PREGS-bit in-list bitmap, set on init fill and free, cleared on allocate.
REQ-029 With FREE_LIST_CHECK_EN, a free of a preg already in list, of preg >= NUM_PREGS, or any free in S_INIT SHALL be dropped and pulse o_err high one cycle.
REQ-030 Without FREE_LIST_CHECK_EN, no bitmap SHALL exist, o_err SHALL be tied 0, and only REQ-017/REQ-024 filtering applies.

Verification
REQ-031 Release reset -> o_init_done rises after 48 cycles; o_free_count=96, o_alloc_preg=32,33, o_alloc_ready=1.
REQ-032 Both lanes request for 48 consecutive cycles -> final grant 126,127; then count=0, o_alloc_ready=0.
REQ-033 At count=0 free {5,0} -> next cycle count=1, ready=0; free {7,0} -> count=2, ready=1, o_alloc_preg=5,7.
REQ-034 At count=2, request both lanes and free {9,11} same cycle -> grants old head pair, count stays 2, next offer 9,11.
REQ-035 Only lane 1 requests at head=32 -> o_alloc_preg[1]=32, head advances by 1; assert i_rst_n=0 mid-stream -> count=0, S_INIT refill from 32.
REQ-036 FREE_LIST_CHECK_EN: after init, free {40,0} -> o_err one-cycle pulse, count remains 96; without macro o_err stays 0, count stays 96 (saturated).
